// File: rtl/io_port_unit_pkg.sv
// Shared widths and watchdog limits for the CPU IN/OUT port buffer.
// Every consumer imports these values, so they change in one place only.
package io_port_unit_pkg;

    localparam int IO_DATA_W = 16;
    localparam int IO_WDOG_W = 8;

    typedef logic [IO_WDOG_W-1:0] wdog_t;

    localparam wdog_t IO_WDOG_MAX = 8'hFF;

    // Watchdog threshold: the stall cycle that moves the counter onto IO_WDOG_MAX raises ovf_err.
    function automatic logic wdog_trips(input wdog_t cnt);
        return cnt == (IO_WDOG_MAX - wdog_t'(1));
    endfunction

endpackage

// File: rtl/io_port_unit_if.sv
// Bundles the execute-stage and peripheral-side port signals of io_port_unit.
// The slave modport is the port unit; the master modport is the CPU/peripheral environment.
interface io_port_unit_if
    import io_port_unit_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W
);
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic              cpu_in_rd;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_out_wr;
    logic [DATA_W-1:0] cpu_out_data;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic              stall_req;
    logic              ovf_err;

    modport slave (
        input  ext_in_data, ext_in_valid, cpu_in_rd, cpu_out_wr, cpu_out_data, ext_out_ready,
        output ext_in_ready, cpu_in_data, ext_out_data, ext_out_valid, stall_req, ovf_err
    );

    modport master (
        output ext_in_data, ext_in_valid, cpu_in_rd, cpu_out_wr, cpu_out_data, ext_out_ready,
        input  ext_in_ready, cpu_in_data, ext_out_data, ext_out_valid, stall_req, ovf_err
    );

endinterface

// File: rtl/io_port_unit_port_fifo.sv
// First-word fall-through FIFO: head word is visible the cycle after its push edge, 0 when empty.
// Pushes while full and pops while empty are ignored; a pop frees room only from the next cycle.
module io_port_unit_port_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Gating on empty keeps the output at zero through reset without clearing the array.
    assign head_data = empty ? '0 : mem[head];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + AW'(1);
            end
            if (do_pop) begin
                head <= head + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// Buffers CPU IN/OUT ports through two FWFT FIFOs; stall_req is combinational, zero latency.
// Peripheral sides use valid/ready; the CPU side is held by stall_req; long OUT stalls latch ovf_err.
module io_port_unit
    import io_port_unit_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic          clk,
    input  logic          RESET,
    io_port_unit_if.slave io
);
    logic [DATA_W-1:0]        in_head;
    logic                     in_full;
    logic                     in_empty;
    logic [$clog2(IN_DEPTH):0] in_count;

    logic [DATA_W-1:0]         out_head;
    logic                      out_full;
    logic                      out_empty;
    logic [$clog2(OUT_DEPTH):0] out_count;

    logic  in_stall;
    logic  out_stall;
    wdog_t wdog_cnt;
    logic  ovf_q;

    io_port_unit_port_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .rst_n     (RESET),
        .push      (io.ext_in_valid),
        .push_data (io.ext_in_data),
        .pop       (io.cpu_in_rd),
        .head_data (in_head),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count)
    );

    io_port_unit_port_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (RESET),
        .push      (io.cpu_out_wr),
        .push_data (io.cpu_out_data),
        .pop       (io.ext_out_ready),
        .head_data (out_head),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    // Occupancy counts are for debug probing only.
    logic unused_counts;
    assign unused_counts = &{1'b0, in_count, out_count};

    // Readiness comes only from occupancy, so the producer never waits on an IN instruction.
    assign io.ext_in_ready  = ~in_full;
    assign io.cpu_in_data   = in_head;
    assign io.ext_out_data  = out_head;
    assign io.ext_out_valid = ~out_empty;

    assign in_stall     = io.cpu_in_rd & in_empty;
    assign out_stall    = io.cpu_out_wr & out_full;
    assign io.stall_req = in_stall | out_stall;
    assign io.ovf_err   = ovf_q;

    // The counter saturates so a stall lasting far longer cannot wrap back below the threshold.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            wdog_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (out_stall) begin
            if (wdog_cnt != IO_WDOG_MAX) begin
                wdog_cnt <= wdog_cnt + wdog_t'(1);
            end
            if (wdog_trips(wdog_cnt)) begin
                ovf_q <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end

endmodule
